// File: rtl/dm_pkg.sv
// Shared encodings for the data-memory stage: access size/sign and MMIO register offsets.
package dm_pkg;

    // Access size/sign, shared with the CPU control decoder.
    typedef enum logic [2:0] {
        DM_WORD  = 3'b000,
        DM_HALF  = 3'b001,
        DM_HALFU = 3'b010,
        DM_BYTE  = 3'b011,
        DM_BYTEU = 3'b100
    } dm_ctrl_e;

    // Word offsets inside the MMIO window (addr[3:2]).
    typedef enum logic [1:0] {
        LED   = 2'd0,
        SW    = 2'd1,
        CYCLE = 2'd2,
        FAULT = 2'd3
    } mmio_off_e;

    // Unused encodings behave as full-word accesses.
    function automatic dm_ctrl_e dm_normalize(input logic [2:0] ctrl);
        case (ctrl)
            3'b001:  return DM_HALF;
            3'b010:  return DM_HALFU;
            3'b011:  return DM_BYTE;
            3'b100:  return DM_BYTEU;
            default: return DM_WORD;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_unit_if.sv
// CPU-to-data-memory access bus: one access per cycle, combinational load data.
interface data_mem_unit_if;
    logic        mem_w;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  dm_ctrl;
    logic [31:0] rdata;
    logic        misalign;

    modport master (
        output mem_w, addr, wdata, dm_ctrl,
        input  rdata, misalign
    );

    modport slave (
        input  mem_w, addr, wdata, dm_ctrl,
        output rdata, misalign
    );
endinterface

// File: rtl/dm_lane_align.sv
// Byte-lane steering: store byte enables/data placement and load lane extraction/extension.
module dm_lane_align
    import dm_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  dm_ctrl,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext,
    output logic        misaligned
);
    dm_ctrl_e    size;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    assign size  = dm_normalize(dm_ctrl);
    assign rbyte = rword[{addr_lo, 3'b000} +: 8];
    assign rhalf = addr_lo[1] ? rword[31:16] : rword[15:0];

    // Decode size into lane enables, replicated store data and the extended load value.
    always_comb begin
        misaligned = 1'b0;
        byte_en    = 4'b0000;
        wdata_lane = 32'b0;
        rdata_ext  = 32'b0;
        case (size)
            DM_BYTE, DM_BYTEU: begin
                byte_en    = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
                rdata_ext  = (size == DM_BYTE) ? {{24{rbyte[7]}}, rbyte} : {24'b0, rbyte};
            end
            DM_HALF, DM_HALFU: begin
                misaligned = addr_lo[0];
                byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{wdata[15:0]}};
                rdata_ext  = (size == DM_HALF) ? {{16{rhalf[15]}}, rhalf} : {16'b0, rhalf};
            end
            default: begin
                misaligned = (addr_lo != 2'b00);
                byte_en    = 4'b1111;
                wdata_lane = wdata;
                rdata_ext  = rword;
            end
        endcase
        // A misaligned access neither writes nor returns data.
        if (misaligned) begin
            byte_en   = 4'b0000;
            rdata_ext = 32'b0;
        end
    end
endmodule

// File: rtl/data_mem_unit.sv
// Data-memory stage endpoint: word RAM with byte lanes plus LED/SW/CYCLE/FAULT MMIO window.
module data_mem_unit
    import dm_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 128,
    parameter logic [15:0] MMIO_HI     = 16'hFFFF
) (
    input  logic                  clk,
    input  logic                  reset,
    data_mem_unit_if.slave        bus,
    input  logic [15:0]           sw_in,
    output logic [15:0]           led_out
);
    localparam int unsigned IdxW = $clog2(DEPTH_WORDS);

    logic [31:0]     ram [DEPTH_WORDS];
    logic [15:0]     led_q, led_d;
    logic [15:0]     sw_meta_q, sw_sync_q;
    logic [31:0]     cycle_q, cycle_d;
    logic [31:0]     fault_q, fault_d;

    logic            mmio, is_word, illegal_mmio, lane_misaligned, bad_access;
    logic            ram_we, mmio_we;
    logic [IdxW-1:0] ram_idx;
    mmio_off_e       mmio_off;
    logic [31:0]     ram_word, mmio_word, rword, rdata_ext, wdata_lane;
    logic [3:0]      byte_en;

    assign mmio         = (bus.addr[31:16] == MMIO_HI);
    assign ram_idx      = bus.addr[IdxW+1:2];
    assign mmio_off     = mmio_off_e'(bus.addr[3:2]);
    assign is_word      = (dm_normalize(bus.dm_ctrl) == DM_WORD);
    assign illegal_mmio = mmio && !is_word;
    assign bad_access   = lane_misaligned || illegal_mmio;
    assign ram_word     = ram[ram_idx];
    // Reset gates the write so a store caught by reset never commits.
    assign ram_we       = reset && bus.mem_w && !mmio && !bad_access;
    assign mmio_we      = bus.mem_w && mmio && !bad_access;
    assign rword        = mmio ? mmio_word : ram_word;

    dm_lane_align u_lane_align (
        .addr_lo    (bus.addr[1:0]),
        .dm_ctrl    (bus.dm_ctrl),
        .wdata      (bus.wdata),
        .rword      (rword),
        .byte_en    (byte_en),
        .wdata_lane (wdata_lane),
        .rdata_ext  (rdata_ext),
        .misaligned (lane_misaligned)
    );

    assign bus.rdata    = illegal_mmio ? 32'b0 : rdata_ext;
    assign bus.misalign = bad_access;
    assign led_out      = led_q;

    // MMIO read mux.
    always_comb begin
        unique case (mmio_off)
            LED:   mmio_word = {16'b0, led_q};
            SW:    mmio_word = {16'b0, sw_sync_q};
            CYCLE: mmio_word = cycle_q;
            FAULT: mmio_word = fault_q;
        endcase
    end

    // MMIO next state: stores override, fault capture beats a clearing store.
    always_comb begin
        led_d   = led_q;
        cycle_d = cycle_q + 32'd1;
        fault_d = fault_q;
        if (mmio_we) begin
            case (mmio_off)
                LED:     led_d   = bus.wdata[15:0];
                CYCLE:   cycle_d = 32'b0;
                FAULT:   fault_d = 32'b0;
                default: ;
            endcase
        end
        if (bad_access && !fault_q[31]) begin
            fault_d = {1'b1, bus.addr[30:0]};
        end
    end

    // MMIO registers and two-flop switch synchroniser.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            led_q     <= 16'b0;
            cycle_q   <= 32'b0;
            fault_q   <= 32'b0;
            sw_meta_q <= 16'b0;
            sw_sync_q <= 16'b0;
        end else begin
            led_q     <= led_d;
            cycle_q   <= cycle_d;
            fault_q   <= fault_d;
            sw_meta_q <= sw_in;
            sw_sync_q <= sw_meta_q;
        end
    end

    // RAM byte-lane writes; contents are not reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    ram[ram_idx][8*b +: 8] <= wdata_lane[8*b +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_data_mem_unit.sv
// Directed bench for data_mem_unit with a byte-array reference model checked every cycle.
module tb_data_mem_unit;
    import dm_pkg::*;

    localparam int unsigned DEPTH = 128;
    localparam int unsigned NBYTES = DEPTH * 4;

    logic        clk;
    logic        reset;
    logic [15:0] sw_in;
    logic [15:0] led_out;
    data_mem_unit_if bus ();

    data_mem_unit #(.DEPTH_WORDS(DEPTH), .MMIO_HI(16'hFFFF)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .sw_in   (sw_in),
        .led_out (led_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    bit chk_on = 1'b0;

    // Reference state
    logic [7:0]  m_mem [NBYTES];
    bit          m_known [NBYTES];
    logic [15:0] m_led, m_sw1, m_sw2;
    logic [31:0] m_cycle, m_fault;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", name, act, exp);
    endtask

    function automatic int unsigned m_size(input logic [2:0] c);
        if (c == DM_HALF || c == DM_HALFU) return 2;
        if (c == DM_BYTE || c == DM_BYTEU) return 1;
        return 4;
    endfunction

    function automatic bit m_is_mmio(input logic [31:0] a);
        return a[31:16] == 16'hFFFF;
    endfunction

    function automatic bit m_bad(input logic [31:0] a, input logic [2:0] c);
        int unsigned sz = m_size(c);
        if (m_is_mmio(a) && sz != 4) return 1'b1;
        return (a % sz) != 0;
    endfunction

    task automatic m_load(input logic [31:0] a, input logic [2:0] c,
                          output logic [31:0] v, output bit known);
        int unsigned sz = m_size(c);
        int unsigned base = a % NBYTES;
        bit sgn = (c == DM_HALF || c == DM_BYTE);
        v = 32'b0;
        known = 1'b1;
        if (m_bad(a, c)) return;
        if (m_is_mmio(a)) begin
            case (a[3:2])
                2'd0:    v = {16'b0, m_led};
                2'd1:    v = {16'b0, m_sw2};
                2'd2:    v = m_cycle;
                default: v = m_fault;
            endcase
            return;
        end
        for (int i = 0; i < int'(sz); i++) begin
            v = v | (32'(m_mem[base + i]) << (8 * i));
            known = known & m_known[base + i];
        end
        if (sgn && sz < 4 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8 * sz));
    endtask

    // Model update on each clock edge from the access presented during the cycle.
    always @(posedge clk) begin
        if (reset) begin
            logic [31:0] a;
            int unsigned sz, base;
            logic [31:0] next_cycle;
            bit bad;
            a = bus.addr;
            sz = m_size(bus.dm_ctrl);
            base = a % NBYTES;
            bad = m_bad(a, bus.dm_ctrl);
            next_cycle = m_cycle + 1;
            if (bus.mem_w && !bad) begin
                if (m_is_mmio(a)) begin
                    if (a[3:2] == 2'd0) m_led = bus.wdata[15:0];
                    if (a[3:2] == 2'd2) next_cycle = 0;
                    if (a[3:2] == 2'd3) m_fault = 0;
                end else begin
                    for (int i = 0; i < int'(sz); i++) begin
                        m_mem[base + i] = bus.wdata[8*i +: 8];
                        m_known[base + i] = 1'b1;
                    end
                end
            end
            if (bad && !m_fault[31]) m_fault = {1'b1, a[30:0]};
            m_cycle = next_cycle;
            m_sw2 = m_sw1;
            m_sw1 = sw_in;
        end
    end

    always @(negedge reset) begin
        m_led = 0; m_cycle = 0; m_fault = 0; m_sw1 = 0; m_sw2 = 0;
    end

    // Per-cycle comparison against the model, mid-cycle.
    always @(negedge clk) begin
        if (reset && chk_on) begin
            logic [31:0] exp;
            bit known;
            m_load(bus.addr, bus.dm_ctrl, exp, known);
            if (!bus.mem_w && known) check("model_rdata", bus.rdata, exp);
            check("model_misalign", {31'b0, bus.misalign}, {31'b0, m_bad(bus.addr, bus.dm_ctrl)});
            check("model_led", {16'b0, led_out}, {16'b0, m_led});
        end
    end

    task automatic drive(input bit w, input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] c);
        bus.mem_w = w; bus.addr = a; bus.wdata = d; bus.dm_ctrl = c;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input bit w, input logic [31:0] a, input logic [31:0] d,
                      input logic [2:0] c);
        drive(w, a, d, c);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] ca, cb;
        for (int i = 0; i < int'(NBYTES); i++) m_known[i] = 1'b0;
        m_led = 0; m_cycle = 0; m_fault = 0; m_sw1 = 0; m_sw2 = 0;
        sw_in = 16'h0;
        reset = 1'b1;
        drive(0, 32'h0, 32'h0, DM_WORD);
        reset = 1'b0;
        drive(0, 32'hFFFF_0008, 0, DM_WORD); check("rst_cycle", bus.rdata, 32'h0);
        drive(0, 32'hFFFF_000C, 0, DM_WORD); check("rst_fault", bus.rdata, 32'h0);
        check("rst_led", {16'b0, led_out}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        chk_on = 1'b1;
        op(0, 32'h0, 0, DM_WORD);

        // Loads with extension
        op(1, 32'h10, 32'h80FF_7F01, DM_WORD);
        drive(0, 32'h10, 0, DM_BYTE);  check("lb_10", bus.rdata, 32'h0000_0001);
        drive(0, 32'h11, 0, DM_BYTE);  check("lb_11", bus.rdata, 32'h0000_007F);
        drive(0, 32'h13, 0, DM_BYTEU); check("lbu_13", bus.rdata, 32'h0000_0080);
        drive(0, 32'h12, 0, DM_HALF);  check("lh_12", bus.rdata, 32'hFFFF_80FF);
        drive(0, 32'h12, 0, DM_HALFU); check("lhu_12", bus.rdata, 32'h0000_80FF);
        tick();

        // Sub-word stores
        op(1, 32'h12, 32'hAAAA_AA55, DM_BYTE);
        op(1, 32'h10, 32'h1234_1234, DM_HALF);
        drive(0, 32'h10, 0, DM_WORD); check("lw_10", bus.rdata, 32'h8055_1234);
        tick();

        // Misalignment and fault capture
        op(1, 32'h20, 32'h0102_0304, DM_WORD);
        drive(1, 32'h22, 32'h1234_5678, DM_WORD);
        check("sw22_misalign", {31'b0, bus.misalign}, 32'h1);
        tick();
        drive(0, 32'h20, 0, DM_WORD); check("lw_20_kept", bus.rdata, 32'h0102_0304);
        drive(0, 32'hFFFF_000C, 0, DM_WORD); check("fault_cap", bus.rdata, 32'h8000_0022);
        tick();
        op(0, 32'h31, 0, DM_HALF);
        drive(0, 32'hFFFF_000C, 0, DM_WORD); check("fault_sticky", bus.rdata, 32'h8000_0022);
        tick();
        op(1, 32'hFFFF_000C, 32'h0, DM_WORD);
        drive(0, 32'hFFFF_000C, 0, DM_WORD); check("fault_clr", bus.rdata, 32'h0);
        tick();

        // Address wrap
        op(1, DEPTH * 4, 32'hDEAD_BEEF, DM_WORD);
        drive(0, 32'h0, 0, DM_WORD); check("wrap", bus.rdata, 32'hDEAD_BEEF);
        tick();

        // LED and switches
        op(1, 32'hFFFF_0000, 32'h0001_A5A5, DM_WORD);
        check("led_a5", {16'b0, led_out}, 32'h0000_A5A5);
        sw_in = 16'h1234;
        op(0, 32'h0, 0, DM_WORD);
        op(0, 32'h0, 0, DM_WORD);
        drive(0, 32'hFFFF_0004, 0, DM_WORD); check("sw_sync", bus.rdata, 32'h0000_1234);
        tick();
        drive(1, 32'hFFFF_0000, 32'h0000_FFFF, DM_BYTE);
        check("sb_led_misalign", {31'b0, bus.misalign}, 32'h1);
        check("sb_led_rdata", bus.rdata, 32'h0);
        tick();
        check("led_kept", {16'b0, led_out}, 32'h0000_A5A5);

        // Cycle counter
        drive(0, 32'hFFFF_0008, 0, DM_WORD); ca = bus.rdata;
        tick(); tick();
        cb = bus.rdata;
        check("cycle_delta", cb - ca, 32'd2);
        op(1, 32'hFFFF_0008, 32'h0000_0123, DM_WORD);
        drive(0, 32'hFFFF_0008, 0, DM_WORD); check("cycle_clr", bus.rdata, 32'h0);
        @(negedge clk);
        #1;
        force dut.cycle_q = 32'hFFFF_FFFF;
        m_cycle = 32'hFFFF_FFFF;
        #1;
        release dut.cycle_q;
        drive(0, 32'hFFFF_0008, 0, DM_WORD); check("cycle_pre", bus.rdata, 32'hFFFF_FFFF);
        tick();
        check("cycle_wrap", bus.rdata, 32'h0);

        // Reset in the middle of a store
        op(1, 32'h40, 32'h1111_1111, DM_WORD);
        drive(1, 32'h40, 32'h2222_2222, DM_WORD);
        chk_on = 1'b0;
        reset = 1'b0;
        #1;
        check("rst_led_now", {16'b0, led_out}, 32'h0);
        tick();
        drive(0, 32'hFFFF_0008, 0, DM_WORD); check("rst_cycle_now", bus.rdata, 32'h0);
        drive(0, 32'hFFFF_000C, 0, DM_WORD); check("rst_fault_now", bus.rdata, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        chk_on = 1'b1;
        drive(0, 32'h40, 0, DM_WORD); check("rst_no_write", bus.rdata, 32'h1111_1111);
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
